if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage_pkg.sv | 22 ++
 rtl/if_stage_pc_reg.sv | 28 ++
 rtl/if_stage.sv | 142 ++++++++++++++
 tb/tb_if_stage.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM states, default
// reset PC and bubble instruction, PC step and the address-alignment helper.
// Imported by the fetch stage top and its PC register.
package if_stage_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    DROP = 2'd3
  } state_t;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEF_NOP_INST = 32'h0000_0000;
  localparam logic [31:0] PC_STEP      = 32'd4;

  // Force a fetch address onto a word boundary.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_stage_pc_reg.sv
// Fetch PC register: reset load, aligned redirect load, or +4 step.
// Latency: new value visible one edge after the request.
// Backpressure: none; the fetch FSM decides when to step or load.
module pc_reg
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  input  logic        load,
  input  logic [31:0] load_pc,
  output logic [31:0] pc
);

  // Reset beats a redirect load, which beats a sequential step.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= align_pc(load_pc);
    end else if (inc) begin
      pc <= pc + PC_STEP;  // wraps modulo 2^32
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: issues imem reads and presents one instruction slot to decode.
// Latency: one edge from an accepted ack to out_valid; one instruction/cycle with zero-wait memory.
// Backpressure: in_stall holds the slot; one extra fetched word parks in a buffer (HOLD, no request).
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter logic [31:0] NOP_INST = DEF_NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  output logic        out_imem_req,
  output logic [31:0] out_imem_addr,
  input  logic        in_imem_ack,
  input  logic [31:0] in_imem_data,
  input  logic        in_stall,
  input  logic        in_redirect_enable,
  input  logic [31:0] in_redirect_pc,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic        out_valid
);

  state_t      state, state_nxt;
  logic [31:0] fetch_pc;
  logic        pc_inc, pc_load;

  // Request still in flight on the pre-redirect address while in DROP.
  logic [31:0] drop_addr, drop_addr_nxt;

  // One-entry buffer; its contents are meaningful only in HOLD.
  logic [31:0] buf_pc, buf_pc_nxt;
  logic [31:0] buf_inst, buf_inst_nxt;

  logic        valid_nxt;
  logic [31:0] pc_nxt, inst_nxt;
  logic        consumable;

  pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk     (clk),
    .rst     (rst),
    .inc     (pc_inc),
    .load    (pc_load),
    .load_pc (in_redirect_pc),
    .pc      (fetch_pc)
  );

  assign consumable    = !out_valid || !in_stall;
  assign out_imem_req  = (state == REQ) || (state == DROP);
  // DROP keeps the abandoned address stable until memory answers it.
  assign out_imem_addr = (state == DROP) ? drop_addr : fetch_pc;

  // Next-state, slot, buffer and PC-control decode; redirect wins over everything.
  always_comb begin
    state_nxt     = state;
    valid_nxt     = out_valid;
    pc_nxt        = out_pc;
    inst_nxt      = out_inst;
    buf_pc_nxt    = buf_pc;
    buf_inst_nxt  = buf_inst;
    drop_addr_nxt = drop_addr;
    pc_inc        = 1'b0;
    pc_load       = 1'b0;

    if (in_redirect_enable) begin
      pc_load   = 1'b1;
      valid_nxt = 1'b0;
      inst_nxt  = NOP_INST;
      case (state)
        REQ: begin
          if (in_imem_ack) begin
            state_nxt = REQ;
          end else begin
            state_nxt     = DROP;
            drop_addr_nxt = fetch_pc;
          end
        end
        DROP:    state_nxt = DROP;
        default: state_nxt = REQ;
      endcase
    end else begin
      // Slot drained with nothing to replace it becomes a bubble.
      if (consumable) begin
        valid_nxt = 1'b0;
        inst_nxt  = NOP_INST;
      end
      case (state)
        IDLE: state_nxt = REQ;
        REQ: begin
          if (in_imem_ack) begin
            pc_inc = 1'b1;
            if (consumable) begin
              valid_nxt = 1'b1;
              pc_nxt    = fetch_pc;
              inst_nxt  = in_imem_data;
            end else begin
              buf_pc_nxt   = fetch_pc;
              buf_inst_nxt = in_imem_data;
              state_nxt    = HOLD;
            end
          end
        end
        HOLD: begin
          if (consumable) begin
            valid_nxt = 1'b1;
            pc_nxt    = buf_pc;
            inst_nxt  = buf_inst;
            state_nxt = REQ;
          end
        end
        DROP: begin
          if (in_imem_ack) state_nxt = REQ;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State, output slot and buffer registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_pc    <= 32'h0000_0000;
      out_inst  <= NOP_INST;
      buf_pc    <= 32'h0000_0000;
      buf_inst  <= 32'h0000_0000;
      drop_addr <= 32'h0000_0000;
    end else begin
      state     <= state_nxt;
      out_valid <= valid_nxt;
      out_pc    <= pc_nxt;
      out_inst  <= inst_nxt;
      buf_pc    <= buf_pc_nxt;
      buf_inst  <= buf_inst_nxt;
      drop_addr <= drop_addr_nxt;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios with literal expectations, then
// randomized stall/redirect/ack/reset traffic against a queue-based model.
// The model tracks the slot, a pending-instruction queue and a stale request.
module tb_if_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        out_imem_req;
  logic [31:0] out_imem_addr;
  logic        in_imem_ack;
  logic [31:0] in_imem_data;
  logic        in_stall;
  logic        in_redirect_enable;
  logic [31:0] in_redirect_pc;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_valid;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 0;

  if_stage #(
    .RESET_PC (RST_PC),
    .NOP_INST (NOP)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .out_imem_req       (out_imem_req),
    .out_imem_addr      (out_imem_addr),
    .in_imem_ack        (in_imem_ack),
    .in_imem_data       (in_imem_data),
    .in_stall           (in_stall),
    .in_redirect_enable (in_redirect_enable),
    .in_redirect_pc     (in_redirect_pc),
    .out_pc             (out_pc),
    .out_inst           (out_inst),
    .out_valid          (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  bit          m_first      = 1;   // the single dead cycle after reset
  logic [31:0] m_fetch      = RST_PC;
  bit          m_stale      = 0;   // a redirected-away request is still in flight
  logic [31:0] m_stale_addr = 0;
  ent_t        m_pend[$];          // fetched but not yet presented
  bit          m_sv         = 0;
  logic [31:0] m_spc        = 0;
  logic [31:0] m_sinst      = NOP;

  function automatic bit m_req();
    return !m_first && (m_pend.size() == 0);
  endfunction

  function automatic logic [31:0] m_addr();
    return m_stale ? m_stale_addr : m_fetch;
  endfunction

  task automatic model_update();
    bit   req, free, got;
    ent_t e;
    if (rst) begin
      m_first = 1; m_fetch = RST_PC; m_stale = 0; m_stale_addr = 0;
      m_pend.delete(); m_sv = 0; m_spc = 0; m_sinst = NOP;
      return;
    end
    req  = m_req();
    free = !m_sv || !in_stall;
    got  = 0;
    e    = '0;
    if (in_redirect_enable) begin
      if (!m_stale) begin
        if (req && !in_imem_ack) begin
          m_stale = 1; m_stale_addr = m_fetch;
        end
      end
      m_fetch = {in_redirect_pc[31:2], 2'b00};
      m_first = 0;
      m_pend.delete();
      m_sv = 0; m_sinst = NOP;
      return;
    end
    if (m_first) begin
      m_first = 0;
    end else if (m_stale) begin
      if (in_imem_ack) m_stale = 0;
    end else if (m_pend.size() != 0) begin
      if (free) begin e = m_pend.pop_front(); got = 1; end
    end else if (in_imem_ack) begin
      e.pc = m_fetch; e.inst = in_imem_data;
      m_fetch = m_fetch + 32'd4;
      if (free) got = 1; else m_pend.push_back(e);
    end
    if (got) begin
      m_sv = 1; m_spc = e.pc; m_sinst = e.inst;
    end else if (free) begin
      m_sv = 0; m_sinst = NOP;
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Every cycle, compare DUT outputs with the model away from the clock edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("req", {31'd0, out_imem_req}, {31'd0, m_req()});
      if (m_req()) chk("addr", out_imem_addr, m_addr());
      chk("valid", {31'd0, out_valid}, {31'd0, m_sv});
      chk("inst", out_inst, m_sinst);
      if (m_sv) chk("pc", out_pc, m_spc);
    end
  end

  // One clock of stimulus; memory acks only while a request is expected.
  task automatic step(input bit r, input bit s, input bit rd, input logic [31:0] rpc,
                      input bit want_ack);
    rst                = r;
    in_stall           = s;
    in_redirect_enable = rd;
    in_redirect_pc     = rpc;
    in_imem_ack        = want_ack && (r || m_req());
    in_imem_data       = $urandom;
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  initial begin
    bit          r, s, rd, burst;
    logic [31:0] rpc;

    rst = 1; in_stall = 0; in_redirect_enable = 0; in_redirect_pc = 0;
    in_imem_ack = 0; in_imem_data = 0;

    // Reset with ack activity that must be ignored.
    step(1, 0, 0, 0, 1);
    chk_en = 1;
    step(1, 1, 1, 32'h40, 1);
    step(1, 0, 0, 0, 1);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_pc", out_pc, 32'h0);
    chk("rst_inst", out_inst, NOP);
    chk("rst_req", {31'd0, out_imem_req}, 32'd0);

    // Zero-wait streaming: request one cycle after release, then 0,4,8,12.
    step(0, 0, 0, 0, 1);
    chk("first_req", {31'd0, out_imem_req}, 32'd1);
    chk("first_addr", out_imem_addr, 32'h0);
    step(0, 0, 0, 0, 1);
    chk("stream_pc0", out_pc, 32'h0);
    step(0, 0, 0, 0, 1);
    chk("stream_pc4", out_pc, 32'h4);
    step(0, 0, 0, 0, 1);
    chk("stream_pc8", out_pc, 32'h8);
    step(0, 0, 0, 0, 1);
    chk("stream_pc12", out_pc, 32'hC);
    chk("stream_valid", {31'd0, out_valid}, 32'd1);

    // Ack withheld for three cycles on address 0x10.
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0);
      chk("wait_addr", out_imem_addr, 32'h10);
    end
    step(0, 0, 0, 0, 1);
    chk("late_pc", out_pc, 32'h10);
    chk("late_valid", {31'd0, out_valid}, 32'd1);

    // Stall with a full slot while an ack lands: buffered, then released.
    step(0, 1, 0, 0, 1);
    chk("hold_req", {31'd0, out_imem_req}, 32'd0);
    chk("hold_pc", out_pc, 32'h10);
    step(0, 1, 0, 0, 0);
    chk("hold_pc2", out_pc, 32'h10);
    step(0, 0, 0, 0, 0);
    chk("unhold_pc", out_pc, 32'h14);
    chk("unhold_req", {31'd0, out_imem_req}, 32'd1);
    chk("unhold_addr", out_imem_addr, 32'h18);

    // Redirect to 0x102 while 0x18 is pending: stale data must vanish.
    step(0, 0, 1, 32'h0000_0102, 0);
    chk("drop_addr", out_imem_addr, 32'h18);
    chk("drop_inst", out_inst, NOP);
    step(0, 0, 0, 0, 0);
    chk("drop_addr2", out_imem_addr, 32'h18);
    step(0, 0, 0, 0, 1);
    chk("drop_inst2", out_inst, NOP);
    chk("drop_valid", {31'd0, out_valid}, 32'd0);
    chk("redir_addr", out_imem_addr, 32'h100);
    step(0, 0, 0, 0, 1);
    chk("redir_pc", out_pc, 32'h100);

    // Address wrap at the top of memory.
    step(0, 0, 1, 32'hFFFF_FFFE, 1);
    chk("wrap_addr0", out_imem_addr, 32'hFFFF_FFFC);
    step(0, 0, 0, 0, 1);
    chk("wrap_pc", out_pc, 32'hFFFF_FFFC);
    chk("wrap_addr", out_imem_addr, 32'h0);

    // Reset in the middle of an outstanding acked request.
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1);
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_req", {31'd0, out_imem_req}, 32'd0);
    chk("mid_rst_inst", out_inst, NOP);
    step(0, 0, 0, 0, 1);
    chk("post_rst_addr", out_imem_addr, RST_PC);

    // Randomized traffic.
    burst = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 49) == 0) burst = !burst;
      r   = ($urandom_range(0, 299) == 0);
      s   = ($urandom_range(0, 99) < 30);
      rd  = ($urandom_range(0, 99) < 5);
      rpc = $urandom;
      if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 | (rpc & 32'hF);
      step(r, s, rd, rpc, burst ? 1'b1 : ($urandom_range(0, 1) == 1));
    end

    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
